// File: rtl/reg_file.sv
// Integer register file: 32 x 32-bit, two combinational read ports, one synchronous write port, x0 hardwired to zero.
// Optional write-to-read forwarding is enabled by defining REG_FILE_BYPASS_EN.
module reg_file #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] rs1,
    input  logic [ADDR_WIDTH-1:0] rs2,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0] wd,
    output logic [DATA_WIDTH-1:0] rd1,
    output logic [DATA_WIDTH-1:0] rd2
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    // Index 0 has no storage; reads of x0 are forced to zero below.
    logic [DATA_WIDTH-1:0] regs [1:DEPTH-1];

    logic write_ok;
    assign write_ok = we && (rd != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i < DEPTH; i++) begin
                if (write_ok && (rd == ADDR_WIDTH'(i))) begin
                    regs[i] <= wd;
                end
            end
        end
    end

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (rs1 != '0) begin
            rd1 = regs[rs1];
        end
        if (rs2 != '0) begin
            rd2 = regs[rs2];
        end
`ifdef REG_FILE_BYPASS_EN
        // Forward the pending write; suppressed during reset so outputs stay zero.
        if (!rst && write_ok && (rs1 == rd)) begin
            rd1 = wd;
        end
        if (!rst && write_ok && (rs2 == rd)) begin
            rd2 = wd;
        end
`endif
    end

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios plus randomized traffic against an array model.
module tb_reg_file;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we  = 1'b0;
    logic [4:0]  rs1 = '0;
    logic [4:0]  rs2 = '0;
    logic [4:0]  rd  = '0;
    logic [31:0] wd  = '0;
    logic [31:0] rd1;
    logic [31:0] rd2;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model [32];

    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk(clk),
        .rst(rst),
        .we (we),
        .rs1(rs1),
        .rs2(rs2),
        .rd (rd),
        .wd (wd),
        .rd1(rd1),
        .rd2(rd2)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] expect_read(input logic [4:0] idx);
        if (idx == 5'd0) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
        if (!rst && we && rd != 5'd0 && rd == idx) return wd;
`endif
        return model[idx];
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1;
        rd = a;
        wd = d;
        @(posedge clk);
        #1;
        if (a != 5'd0) model[a] = d;
        we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_model();
        for (int i = 1; i < 32; i++) do_write(5'(i), 32'hA5A5_0000 + 32'(i));
        rs1 = 5'd17;
        #1;
        n_checks++;
        if (rd1 !== 32'hA5A5_0011) begin
            n_fail++;
            $display("FAIL preload_x17: got %h expected %h", rd1, 32'hA5A5_0011);
        end
        #1;
        rst = 1'b1;
        #1;
        clear_model();
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(31 - i);
            #1;
            n_checks++;
            if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_held idx=%0d: rd1=%h rd2=%h expected 0", i, rd1, rd2);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rs1 = 5'(i);
            rs2 = 5'(31 - i);
            #1;
            n_checks++;
            if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_released idx=%0d: rd1=%h rd2=%h expected 0", i, rd1, rd2);
            end
        end
    endtask

    task automatic test_basic();
        do_write(5'd5, 32'h1234_5678);
        do_write(5'd31, 32'hFFFF_FFFF);
        rs1 = 5'd5;
        rs2 = 5'd31;
        #1;
        n_checks++;
        if (rd1 !== 32'h1234_5678 || rd2 !== 32'hFFFF_FFFF) begin
            n_fail++;
            $display("FAIL basic_rw: rd1=%h rd2=%h expected 12345678 ffffffff", rd1, rd2);
        end
        for (int i = 1; i < 31; i++) begin
            if (i == 5) continue;
            rs1 = 5'(i);
            #1;
            n_checks++;
            if (rd1 !== 32'h0) begin
                n_fail++;
                $display("FAIL basic_untouched x%0d: got %h expected 0", i, rd1);
            end
        end
    endtask

    task automatic test_x0();
        rs1 = 5'd0;
        rs2 = 5'd0;
        we  = 1'b1;
        rd  = 5'd0;
        wd  = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            n_fail++;
            $display("FAIL x0_before_edge: rd1=%h rd2=%h expected 0", rd1, rd2);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (rd1 !== 32'h0 || rd2 !== 32'h0) begin
            n_fail++;
            $display("FAIL x0_after_edge: rd1=%h rd2=%h expected 0", rd1, rd2);
        end
        we = 1'b0;
    endtask

    task automatic test_we_gating();
        do_write(5'd7, 32'h0000_0001);
        we  = 1'b0;
        rd  = 5'd7;
        wd  = 32'h0000_0002;
        rs1 = 5'd7;
        repeat (3) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (rd1 !== 32'h0000_0001) begin
                n_fail++;
                $display("FAIL we_gating: got %h expected 00000001", rd1);
            end
        end
    endtask

    task automatic test_read_during_write();
        logic [31:0] pre;
        do_write(5'd9, 32'hAAAA_AAAA);
`ifdef REG_FILE_BYPASS_EN
        pre = 32'h5555_5555;
`else
        pre = 32'hAAAA_AAAA;
`endif
        we  = 1'b1;
        rd  = 5'd9;
        wd  = 32'h5555_5555;
        rs1 = 5'd9;
        rs2 = 5'd9;
        #1;
        n_checks++;
        if (rd1 !== pre || rd2 !== pre) begin
            n_fail++;
            $display("FAIL rdw_before_edge: rd1=%h rd2=%h expected %h", rd1, rd2, pre);
        end
        @(posedge clk);
        #1;
        model[9] = 32'h5555_5555;
        we = 1'b0;
        #1;
        n_checks++;
        if (rd1 !== 32'h5555_5555 || rd2 !== 32'h5555_5555) begin
            n_fail++;
            $display("FAIL rdw_after_edge: rd1=%h rd2=%h expected 55555555", rd1, rd2);
        end
    endtask

    task automatic test_reset_during_write();
        we = 1'b1;
        rd = 5'd3;
        wd = 32'h0000_00FF;
        rs1 = 5'd3;
        @(posedge clk);
        rst = 1'b1;
        #1;
        clear_model();
        @(posedge clk);
        #1;
        we  = 1'b0;
        rst = 1'b0;
        #1;
        n_checks++;
        if (rd1 !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_during_write_x3: got %h expected 0", rd1);
        end
        do_write(5'd3, 32'h0000_00FF);
        #1;
        n_checks++;
        if (rd1 !== 32'h0000_00FF) begin
            n_fail++;
            $display("FAIL write_after_reset_x3: got %h expected 000000ff", rd1);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            we  = ($urandom_range(0, 3) != 0);
            rd  = 5'($urandom_range(0, 31));
            wd  = $urandom;
            rs1 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            rs2 = ($urandom_range(0, 3) == 0) ? rd : 5'($urandom_range(0, 31));
            #1;
            n_checks++;
            if (rd1 !== expect_read(rs1) || rd2 !== expect_read(rs2)) begin
                n_fail++;
                $display("FAIL random n=%0d rs1=%0d rs2=%0d: rd1=%h rd2=%h expected %h %h",
                         n, rs1, rs2, rd1, rd2, expect_read(rs1), expect_read(rs2));
            end
            @(posedge clk);
            #1;
            if (we && rd != 5'd0) model[rd] = wd;
        end
        we = 1'b0;
    endtask

    initial begin
        clear_model();
        test_reset();
        test_basic();
        test_x0();
        test_we_gating();
        test_read_during_write();
        test_reset_during_write();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
